// File: rtl/mult4_acc_stage.sv
// Accumulates a burst of 8-bit multiplier products and presents the sum and count.
// A burst closes on in_last or when MAX_N products have been taken.
module mult4_acc_stage #(
    parameter int unsigned ACC_W = 12,
    parameter int unsigned MAX_N = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [7:0]       cnt_out,
    output logic             trunc_out
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_N);

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt, acc_sum, prod_ext;
    logic [7:0]       cnt, cnt_nxt, cnt_inc;
    logic             trunc, trunc_nxt;
    logic             xfer, close, drain;

    assign prod_ext = ACC_W'(prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath terms shared by the next-state and register-update logic.
    always_comb begin
        xfer    = in_valid && in_ready;
        drain   = (state == HOLD) && out_ready;
        cnt_inc = (state == IDLE) ? 8'd1 : cnt + 8'd1;
        acc_sum = (state == IDLE) ? prod_ext : acc + prod_ext;
        close   = xfer && (in_last || (cnt_inc == MAX_CNT));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: begin
                if (close) begin
                    state_nxt = HOLD;
                end else if (xfer) begin
                    state_nxt = ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        trunc_nxt = trunc;
        if (xfer) begin
            acc_nxt   = acc_sum;
            cnt_nxt   = cnt_inc;
            trunc_nxt = (cnt_inc == MAX_CNT) && !in_last;
        end else if (drain) begin
            acc_nxt   = '0;
            cnt_nxt   = '0;
            trunc_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            trunc <= 1'b0;
        end else begin
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            trunc <= trunc_nxt;
        end
    end

    // Result fields are gated by state so they read zero outside HOLD.
    always_comb begin
        in_ready  = (state != HOLD);
        out_valid = (state == HOLD);
        acc_out   = '0;
        cnt_out   = '0;
        trunc_out = 1'b0;
        if (state == HOLD) begin
            acc_out   = acc;
            cnt_out   = cnt;
            trunc_out = trunc;
        end
    end

endmodule

// File: tb/tb_mult4_acc_stage.sv
// Directed-vector bench for mult4_acc_stage with hand-computed expectations.
module tb_mult4_acc_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  prod;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] acc_out;
    logic [7:0]  cnt_out;
    logic        trunc_out;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    mult4_acc_stage #(.ACC_W(12), .MAX_N(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .cnt_out   (cnt_out),
        .trunc_out (trunc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] p, input logic last);
        in_valid = 1'b1;
        prod     = p;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] c,
                                input logic t);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_acc"},   32'(acc_out), a);
        check({tag, "_cnt"},   32'(cnt_out), c);
        check({tag, "_trunc"}, 32'(trunc_out), 32'(t));
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        check({tag, "_drained_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_drained_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_drained_acc"},   32'(acc_out), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        prod      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_acc",   32'(acc_out), 32'd0);
        check("rst_cnt",   32'(cnt_out), 32'd0);
        check("rst_trunc", 32'(trunc_out), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Single product, consumer always ready.
        out_ready = 1'b1;
        send(8'd225, 1'b1);
        check_result("single", 32'd225, 32'd1, 1'b0);
        tick();
        check("single_after_valid", 32'(out_valid), 32'd0);
        check("single_after_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Three-product burst.
        send(8'd6, 1'b0);
        check("b3_ready1", 32'(in_ready), 32'd1);
        check("b3_valid1", 32'(out_valid), 32'd0);
        send(8'd9, 1'b0);
        check("b3_ready2", 32'(in_ready), 32'd1);
        send(8'd20, 1'b1);
        check_result("b3", 32'd35, 32'd3, 1'b0);
        drain("b3");

        // MAX_N limit closes the burst without in_last.
        for (int i = 0; i < 15; i++) send(8'd225, 1'b0);
        check("lim15_valid", 32'(out_valid), 32'd0);
        check("lim15_ready", 32'(in_ready), 32'd1);
        send(8'd225, 1'b0);
        check_result("lim", 32'd3600, 32'd16, 1'b1);
        in_valid  = 1'b1;
        prod      = 8'd7;
        in_last   = 1'b1;
        out_ready = 1'b1;
        tick();
        check("lim_hs_valid", 32'(out_valid), 32'd0);
        check("lim_hs_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result("lim17", 32'd7, 32'd1, 1'b0);
        drain("lim17");

        // Backpressure: result held four cycles, inputs blocked.
        send(8'd10, 1'b0);
        send(8'd5, 1'b1);
        check_result("bp1", 32'd15, 32'd2, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            in_valid = 1'b1;
            prod     = 8'd99;
            tick();
            check_result($sformatf("bp%0d", i), 32'd15, 32'd2, 1'b0);
        end
        in_valid = 1'b0;
        drain("bp5");

        // Asynchronous reset between edges discards the partial burst.
        send(8'd100, 1'b0);
        send(8'd50, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_acc",   32'(acc_out), 32'd0);
        check("arst_cnt",   32'(cnt_out), 32'd0);
        #1 rst = 1'b0;
        send(8'd3, 1'b1);
        check_result("arst_burst", 32'd3, 32'd1, 1'b0);
        drain("arst_burst");

        // Zero product counts; bubbles with stray in_last are ignored.
        send(8'd0, 1'b0);
        in_last = 1'b1;
        tick();
        check("bub1_valid", 32'(out_valid), 32'd0);
        tick();
        check("bub2_valid", 32'(out_valid), 32'd0);
        check("bub2_ready", 32'(in_ready), 32'd1);
        in_last = 1'b0;
        send(8'd4, 1'b1);
        check_result("zero", 32'd4, 32'd2, 1'b0);
        drain("zero");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult4_acc_stage.md
MULT4_ACC_STAGE -- requirements
Module: mult4_acc_stage

Interface
REQ-001 SHALL have parameter ACC_W, default 12, accumulator/result width in bits.
REQ-002 SHALL have parameter MAX_N, default 16, maximum products per burst; legal configurations SHALL satisfy ACC_W >= 8 + clog2(MAX_N) and 2 <= MAX_N <= 255.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  product on prod is valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept a product this cycle.
REQ-007 SHALL have port prod  input  8  unsigned product, driven by the 4x4 multiplier output o[7:0].
REQ-008 SHALL have port in_last  input  1  qualifies prod as the final product of the burst.
REQ-009 SHALL have port out_valid  output  1  result fields are valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port acc_out  output  ACC_W  unsigned sum of the burst's products.
REQ-012 SHALL have port cnt_out  output  8  number of products in the burst (1..MAX_N).
REQ-013 SHALL have port trunc_out  output  1  burst closed by the MAX_N limit, not by in_last.

Function
REQ-014 SHALL implement states IDLE (no partial sum), ACCUM (partial sum held), and HOLD (result presented).
REQ-015 A transfer SHALL occur when in_valid && in_ready at a rising edge; in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD, and SHALL depend only on state.
REQ-016 On a transfer in IDLE, acc SHALL load zero-extended prod and cnt SHALL load 1; in ACCUM, acc SHALL load acc + prod and cnt SHALL load cnt + 1.
REQ-017 A transfer SHALL close the burst when in_last = 1 or the new cnt equals MAX_N: next state HOLD, out_valid = 1 in the following cycle, trunc_out = (new cnt == MAX_N) && !in_last.
REQ-018 A transfer that does not close the burst SHALL move the state to ACCUM (or keep it there).
REQ-019 Latency SHALL be exactly one cycle from the closing transfer edge to out_valid high, with acc_out/cnt_out including the closing product.
REQ-020 In HOLD, acc_out, cnt_out, trunc_out and out_valid SHALL hold stable until out_valid && out_ready at a rising edge.
REQ-021 On that handshake, the state SHALL go to IDLE and out_valid SHALL be 0 in the next cycle; the internal acc and cnt SHALL clear to 0.
REQ-022 No product SHALL be accepted in the handshake cycle; the next burst starts no earlier than the following cycle.
REQ-023 The accumulator SHALL never overflow under legal parameters (16 x 225 = 3600 < 4096); no wrap logic is required.
REQ-024 prod = 0 SHALL count as a product (increments cnt).
REQ-025 in_last SHALL be ignored when no transfer occurs.
REQ-026 out_ready SHALL be ignored while out_valid = 0.
REQ-027 Outside HOLD, acc_out, cnt_out and trunc_out SHALL read 0.

Reset
REQ-028 Asserting rst SHALL immediately (without a clock) force state IDLE, acc = 0, cnt = 0, out_valid = 0, acc_out = 0, cnt_out = 0 and trunc_out = 0.
REQ-029 Whenever rst is high, in_ready SHALL be 1.
REQ-030 A partial burst or unconsumed result present at reset SHALL be discarded.
REQ-031 The first transfer SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-032 Single product: prod = 8'd225 with in_last = 1, out_ready = 1 -> next cycle out_valid = 1, acc_out = 225, cnt_out = 1, trunc_out = 0; the cycle after, out_valid = 0.
REQ-033 Three-product burst: prod 6, 9, 20 (last on 20), valid every cycle -> acc_out = 35, cnt_out = 3, trunc_out = 0; in_ready stays 1 during the burst.
REQ-034 Limit: 16 transfers of 225 with in_last = 0 -> acc_out = 3600, cnt_out = 16, trunc_out = 1; a 17th prod = 7 starts a new burst only after the handshake.
REQ-035 Backpressure: burst 10, 5 (last) with out_ready = 0 for 4 cycles -> outputs stay 15/2/0 and in_ready stays 0 throughout; the handshake on cycle 5 returns in_ready = 1.
REQ-036 Reset mid-burst: transfer 100 and 50, assert rst asynchronously between edges, then send a burst of 3 (last) -> outputs clear immediately and the result is acc_out = 3, cnt_out = 1.
REQ-037 Bubbles and zeros: prod 0 (valid), in_valid low 2 cycles, then prod 4 with in_last = 1 -> acc_out = 4, cnt_out = 2.
